// File: rtl/range_sweep_pkg.sv
// rtl/range_sweep_pkg.sv - shared widths, FSM state type and helpers for range_sweep
package range_sweep_pkg;

   localparam int DEFAULT_RAM_WORDS  = 16;
   localparam int DEFAULT_LANES      = 2;
   localparam int DEFAULT_N_BITS     = 32;
   localparam int DEFAULT_COUNT_BITS = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } sweep_state_e;

   // Address width for a RAM of the given depth, never narrower than one bit
   function automatic int addr_bits(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/range_sweep_collatz_lane.sv
// rtl/range_sweep_collatz_lane.sv - one Collatz lane: load a start value, step to 1, hold the count
module collatz_lane
   import range_sweep_pkg::*;
#(
   parameter int N_BITS     = DEFAULT_N_BITS,
   parameter int COUNT_BITS = DEFAULT_COUNT_BITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [N_BITS-1:0]     n,
   output logic                  busy,
   output logic                  done,
   output logic [COUNT_BITS-1:0] count,
   input  logic                  ack
);

   localparam logic [COUNT_BITS-1:0] CNT_MAX = {COUNT_BITS{1'b1}};

   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [N_BITS-1:0]     val_q, val_d;
   logic [COUNT_BITS-1:0] cnt_q, cnt_d;
   logic [N_BITS+1:0]     step3;

   // One Collatz step per cycle; the result is held until the top acknowledges the write
   always_comb begin
      busy_d = busy_q;
      done_d = done_q;
      val_d  = val_q;
      cnt_d  = cnt_q;
      step3  = ({2'b00, val_q} << 1) + {2'b00, val_q} + (N_BITS+2)'(1);
      if (load) begin
         busy_d = 1'b1;
         done_d = 1'b0;
         val_d  = n;
         cnt_d  = COUNT_BITS'(1);
      end else if (busy_q) begin
         if (val_q == '0) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            cnt_d  = '0;
         end else if (val_q == N_BITS'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else if (cnt_q == CNT_MAX) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else if (val_q[0] && (step3[N_BITS+1:N_BITS] != 2'b00)) begin
            // 3n+1 no longer fits the datapath: report a saturated count
            busy_d = 1'b0;
            done_d = 1'b1;
            cnt_d  = CNT_MAX;
         end else begin
            val_d = val_q[0] ? step3[N_BITS-1:0] : (val_q >> 1);
            cnt_d = cnt_q + COUNT_BITS'(1);
         end
      end else if (done_q && ack) begin
         done_d = 1'b0;
      end
   end

   // Lane state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         val_q  <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         val_q  <= val_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign count = cnt_q;

endmodule

// File: rtl/range_sweep.sv
// rtl/range_sweep.sv - sweep consecutive start values over Collatz lanes into a count RAM (option: RANGE_SWEEP_MAX_TRACK_EN)
module range_sweep
   import range_sweep_pkg::*;
#(
   parameter int  RAM_WORDS     = DEFAULT_RAM_WORDS,
   parameter int  LANES         = DEFAULT_LANES,
   parameter int  N_BITS        = DEFAULT_N_BITS,
   parameter int  COUNT_BITS    = DEFAULT_COUNT_BITS,
   localparam int RAM_ADDR_BITS = addr_bits(RAM_WORDS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     go,
   input  logic [N_BITS-1:0]        start,
   input  logic [RAM_ADDR_BITS-1:0] rd_addr,
   output logic                     busy,
   output logic                     done,
   output logic [COUNT_BITS-1:0]    count
`ifdef RANGE_SWEEP_MAX_TRACK_EN
   ,
   output logic [COUNT_BITS-1:0]    max_count,
   output logic [N_BITS-1:0]        max_start
`endif
);

   localparam int               CNT_W     = RAM_ADDR_BITS + 1;
   localparam int               RAM_DEPTH = 1 << RAM_ADDR_BITS;
   localparam logic [CNT_W-1:0] LAST_K    = CNT_W'(RAM_WORDS - 1);

   sweep_state_e              state_q, state_d;
   logic [N_BITS-1:0]         start_q, start_d;
   logic [CNT_W-1:0]          issue_q, issue_d;
   logic [CNT_W-1:0]          wr_cnt_q, wr_cnt_d;
   logic                      done_q, done_d;
   logic [COUNT_BITS-1:0]     count_q, count_d;
   logic [RAM_ADDR_BITS-1:0]  tag_q [LANES];
   logic [RAM_ADDR_BITS-1:0]  tag_d [LANES];
   logic [COUNT_BITS-1:0]     ram_q [RAM_DEPTH];

   logic [LANES-1:0]          lane_load, lane_busy, lane_done, lane_ack;
   logic [COUNT_BITS-1:0]     lane_count [LANES];
   logic [N_BITS-1:0]         issue_val;
   logic                      accept_go, issue_en, wr_en, last_wr;
   logic [RAM_ADDR_BITS-1:0]  wr_addr;
   logic [COUNT_BITS-1:0]     wr_data;

   assign accept_go = (state_q == ST_IDLE) && go;
   assign issue_val = start_q + N_BITS'(issue_q);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      collatz_lane #(
         .N_BITS    (N_BITS),
         .COUNT_BITS(COUNT_BITS)
      ) u_lane (
         .clk  (clk),
         .rst_n(rst_n),
         .load (lane_load[g]),
         .n    (issue_val),
         .busy (lane_busy[g]),
         .done (lane_done[g]),
         .count(lane_count[g]),
         .ack  (lane_ack[g])
      );
   end

   // Issue the next start value to the lowest-index idle lane, remembering its RAM slot
   always_comb begin
      issue_en  = 1'b0;
      lane_load = '0;
      for (int i = 0; i < LANES; i++) tag_d[i] = tag_q[i];
      if (state_q == ST_RUN) begin
         for (int i = 0; i < LANES; i++) begin
            if (!issue_en && !lane_busy[i] && !lane_done[i]) begin
               issue_en     = 1'b1;
               lane_load[i] = 1'b1;
               tag_d[i]     = issue_q[RAM_ADDR_BITS-1:0];
            end
         end
      end
   end

   // Grant the single RAM write to the lowest-index lane holding a result
   always_comb begin
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      lane_ack = '0;
      for (int i = 0; i < LANES; i++) begin
         if (!wr_en && lane_done[i]) begin
            wr_en       = 1'b1;
            lane_ack[i] = 1'b1;
            wr_addr     = tag_q[i];
            wr_data     = lane_count[i];
         end
      end
      last_wr = wr_en && (wr_cnt_q == LAST_K);
   end

   // Sweep bookkeeping: latched start, issue/write counters, done pulse and read port
   always_comb begin
      start_d  = start_q;
      issue_d  = issue_q;
      wr_cnt_d = wr_cnt_q;
      if (accept_go) begin
         start_d  = start;
         issue_d  = '0;
         wr_cnt_d = '0;
      end else begin
         if (issue_en) issue_d = issue_q + CNT_W'(1);
         if (wr_en) wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
      done_d  = last_wr && (state_q != ST_IDLE);
      count_d = count_q;
      if (!(wr_en && (wr_addr == rd_addr))) count_d = ram_q[rd_addr];
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (go) state_d = ST_RUN;
         ST_RUN:   if (issue_en && (issue_q == LAST_K)) state_d = ST_FLUSH;
         ST_FLUSH: if (last_wr) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy  = (state_q != ST_IDLE);
      done  = done_q;
      count = count_q;
   end

   // State and control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         start_q  <= '0;
         issue_q  <= '0;
         wr_cnt_q <= '0;
         done_q   <= 1'b0;
         count_q  <= '0;
         for (int i = 0; i < LANES; i++) tag_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         issue_q  <= issue_d;
         wr_cnt_q <= wr_cnt_d;
         done_q   <= done_d;
         count_q  <= count_d;
         for (int i = 0; i < LANES; i++) tag_q[i] <= tag_d[i];
      end
   end

   // Result RAM survives reset so a completed sweep can still be read
   always_ff @(posedge clk) begin
      if (wr_en) ram_q[wr_addr] <= wr_data;
   end

`ifdef RANGE_SWEEP_MAX_TRACK_EN
   logic [COUNT_BITS-1:0] max_count_q, max_count_d;
   logic [N_BITS-1:0]     max_start_q, max_start_d;

   // Track the largest count written; strict compare keeps the earliest on ties
   always_comb begin
      max_count_d = max_count_q;
      max_start_d = max_start_q;
      if (accept_go) begin
         max_count_d = '0;
         max_start_d = '0;
      end else if (wr_en && (wr_data > max_count_q)) begin
         max_count_d = wr_data;
         max_start_d = start_q + N_BITS'(wr_addr);
      end
   end

   // Maximum tracking registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_count_q <= '0;
         max_start_q <= '0;
      end else begin
         max_count_q <= max_count_d;
         max_start_q <= max_start_d;
      end
   end

   assign max_count = max_count_q;
   assign max_start = max_start_q;
`endif

endmodule

// File: tb/tb_range_sweep.sv
// tb/tb_range_sweep.sv - randomized self-checking bench for range_sweep (LANES=1 and LANES=4 side by side)
module tb_range_sweep;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        go;
   logic [31:0] start;
   logic [3:0]  rd_addr;
   logic        busy_a, done_a, busy_b, done_b;
   logic [15:0] count_a, count_b;
`ifdef RANGE_SWEEP_MAX_TRACK_EN
   logic [15:0] max_count_a, max_count_b;
   logic [31:0] max_start_a, max_start_b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   range_sweep #(.RAM_WORDS(16), .LANES(1), .N_BITS(32), .COUNT_BITS(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .go(go), .start(start), .rd_addr(rd_addr),
      .busy(busy_a), .done(done_a), .count(count_a)
`ifdef RANGE_SWEEP_MAX_TRACK_EN
      , .max_count(max_count_a), .max_start(max_start_a)
`endif
   );

   range_sweep #(.RAM_WORDS(16), .LANES(4), .N_BITS(32), .COUNT_BITS(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .go(go), .start(start), .rd_addr(rd_addr),
      .busy(busy_b), .done(done_b), .count(count_b)
`ifdef RANGE_SWEEP_MAX_TRACK_EN
      , .max_count(max_count_b), .max_start(max_start_b)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Number of sequence values from n down to 1, saturating on overflow or count limit
   function automatic logic [15:0] ref_count(input logic [31:0] n0);
      longint unsigned n;
      int c;
      n = 64'(n0);
      if (n == 0) return 16'h0;
      c = 1;
      while (n != 1) begin
         if (c == 65535) return 16'hFFFF;
         if (n % 2 == 1) begin
            n = 3 * n + 1;
            if (n > 64'hFFFF_FFFF) return 16'hFFFF;
         end else begin
            n = n / 2;
         end
         c++;
      end
      return 16'(c);
   endfunction

   task automatic read_both(input int a, output logic [15:0] ra, output logic [15:0] rb);
      @(negedge clk);
      rd_addr = 4'(a);
      @(posedge clk);
      #1;
      ra = count_a;
      rb = count_b;
   endtask

   task automatic run_sweep(input logic [31:0] s, input int mid_go, input bit check_order);
      int na, nb, ca, cb, fin;
      na = 0; nb = 0; ca = 0; cb = 0; fin = 0;
      @(negedge clk);
      start = s;
      go    = 1'b1;
      @(negedge clk);
      go    = 1'b0;
      check("busy_a_running", busy_a, 1);
      check("busy_b_running", busy_b, 1);
      for (int cyc = 1; cyc <= 20000; cyc++) begin
         if (done_a) begin
            na++;
            ca = cyc;
            check("busy_a_low_at_done", busy_a, 0);
         end
         if (done_b) begin
            nb++;
            cb = cyc;
            check("busy_b_low_at_done", busy_b, 0);
         end
         if (na > 0 && nb > 0 && cyc >= ((ca > cb) ? ca : cb) + 4) begin
            fin = 1;
            break;
         end
         go = (cyc == mid_go);
         if (go) start = ~s;
         @(negedge clk);
      end
      go = 1'b0;
      check("sweep_finished", 64'(fin), 1);
      check("done_pulses_a", 64'(na), 1);
      check("done_pulses_b", 64'(nb), 1);
      if (check_order) check("lanes4_done_earlier", 64'(cb < ca), 1);
   endtask

   task automatic verify_ram(input logic [31:0] s);
      logic [15:0] ra, rb, exp;
      for (int k = 0; k < 16; k++) begin
         read_both(k, ra, rb);
         exp = ref_count(s + 32'(k));
         check($sformatf("ram_a[%0d] start=%0h", k, s), ra, exp);
         check($sformatf("ram_b[%0d] start=%0h", k, s), rb, exp);
      end
   endtask

   initial begin
      logic [15:0] tbl [16];
      logic [15:0] ra, rb;
      logic [31:0] s;
      int seen;
      tbl = '{16'd1, 16'd2, 16'd8, 16'd3, 16'd6, 16'd9, 16'd17, 16'd4,
              16'd20, 16'd7, 16'd15, 16'd10, 16'd10, 16'd18, 16'd18, 16'd5};

      rst_n = 1'b0; go = 1'b0; start = '0; rd_addr = '0;
      repeat (3) @(negedge clk);
      check("reset_busy_a", busy_a, 0);
      check("reset_done_a", done_a, 0);
      check("reset_count_a", count_a, 0);
      check("reset_busy_b", busy_b, 0);
      check("reset_count_b", count_b, 0);
      rst_n = 1'b1;

      // Known table for start=1
      run_sweep(32'd1, 0, 1'b1);
      for (int k = 0; k < 16; k++) begin
         read_both(k, ra, rb);
         check($sformatf("table_a[%0d]", k), ra, tbl[k]);
         check($sformatf("table_b[%0d]", k), rb, tbl[k]);
      end
      read_both(7, ra, rb);
      check("rd_addr7_a", ra, 16'd4);
      check("rd_addr7_b", rb, 16'd4);
`ifdef RANGE_SWEEP_MAX_TRACK_EN
      check("max_count_a", max_count_a, 16'd20);
      check("max_start_a", max_start_a, 32'd9);
      check("max_count_b", max_count_b, 16'd20);
      check("max_start_b", max_start_b, 32'd9);
`endif

      // Zero start and wrap-around / overflow corner
      run_sweep(32'd0, 0, 1'b1);
      verify_ram(32'd0);
      read_both(0, ra, rb);
      check("start0_ram0", ra, 16'd0);
      read_both(1, ra, rb);
      check("start0_ram1", ra, 16'd1);
      run_sweep(32'hFFFF_FFFF, 0, 1'b1);
      verify_ram(32'hFFFF_FFFF);
      read_both(0, ra, rb);
      check("overflow_ram0_a", ra, 16'hFFFF);
      check("overflow_ram0_b", rb, 16'hFFFF);

      // go while busy must be ignored
      s = $urandom_range(2, 5000);
      run_sweep(s, 3, 1'b1);
      verify_ram(s);

      // Reset in the middle of a sweep
      @(negedge clk);
      start = 32'd27;
      go    = 1'b1;
      @(negedge clk);
      go    = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy_a", busy_a, 0);
      check("midrst_busy_b", busy_b, 0);
      check("midrst_count_a", count_a, 0);
      check("midrst_done_a", done_a, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (done_a || done_b || busy_a || busy_b) seen = 1;
      end
      check("no_done_after_reset", 64'(seen), 0);
      s = $urandom_range(1, 100000);
      run_sweep(s, 0, 1'b1);
      verify_ram(s);

      // Random sweeps, including full-range starts that may overflow
      for (int r = 0; r < 3; r++) begin
         s = (r == 0) ? 32'($urandom) : 32'($urandom_range(1, 1000000));
         run_sweep(s, 0, 1'b1);
         verify_ram(s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
